fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the pipelined CPU.
- Owns the PC and issues single-outstanding requests to a variable-latency instruction memory over a req/gnt + rvalid handshake.
- Buffers returned instructions in a small FIFO and presents them to decode on a valid/ready interface.
- Supports redirects (branch/jump/flush) that discard queued and in-flight fetches.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_queue.sv | 45 ++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU front end.
package cpu_pkg;

   typedef enum logic [1:0] {
      FS_REQ,
      FS_WAIT,
      FS_DROP
   } fetch_state_t;

   localparam int          ADDR_W_DEF   = 16;
   localparam int          INSTR_W_DEF  = 16;
   localparam int          PC_STEP_DEF  = 2;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instr, pc} pairs for decode.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int W     = 32,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output logic [W-1:0]  head
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem
// requests and queues returned instructions for decode.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   FS_REQ  | no fetch in flight; request when the queue has space
//   FS_WAIT | request granted, waiting for rvalid to push the response
//   FS_DROP | request granted before a redirect, response is discarded
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INSTR_W  = INSTR_W_DEF,
   parameter int                PC_STEP  = PC_STEP_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
   parameter int                QDEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [ADDR_W-1:0]  if_pc_next
);

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam int QW = INSTR_W + ADDR_W;

   fetch_state_t      state;
   fetch_state_t      nxt_state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              req_q;
   logic [CW-1:0]     count;
   logic [CW-1:0]     nxt_count;
   logic [QW-1:0]     head;
   logic              fire;
   logic              push;
   logic              pop;

   assign fire = req_q & imem_gnt;
   assign push = (state == FS_WAIT) & imem_rvalid & ~redirect;
   assign pop  = if_valid & if_ready & ~redirect;

   always_comb begin
      nxt_state = state;
      case (state)
         FS_REQ:  if (fire) nxt_state = redirect ? FS_DROP : FS_WAIT;
         FS_WAIT: begin
            if (imem_rvalid)   nxt_state = FS_REQ;
            else if (redirect) nxt_state = FS_DROP;
         end
         FS_DROP: if (imem_rvalid) nxt_state = FS_REQ;
         default: nxt_state = FS_REQ;
      endcase
   end

   always_comb begin
      nxt_count = count + CW'(push) - CW'(pop);
      if (redirect) nxt_count = '0;
   end

   // imem_req is computed from the next-cycle state and occupancy, so it
   // never depends combinationally on if_ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= FS_REQ;
         fetch_pc    <= RESET_PC;
         inflight_pc <= '0;
         req_q       <= 1'b0;
      end else begin
         state <= nxt_state;
         req_q <= (nxt_state == FS_REQ) && (nxt_count < CW'(QDEPTH));
         if (redirect)  fetch_pc <= redirect_pc;
         else if (fire) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
         if (fire) inflight_pc <= fetch_pc;
      end
   end

   fetch_queue #(
      .DEPTH (QDEPTH),
      .W     (QW)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({imem_rdata, inflight_pc}),
      .pop       (pop),
      .flush     (redirect),
      .count     (count),
      .head      (head)
   );

   assign imem_req   = req_q;
   assign imem_addr  = fetch_pc;
   assign if_valid   = (count != '0);
   assign if_instr   = if_valid ? head[QW-1:ADDR_W] : '0;
   assign if_pc      = if_valid ? head[ADDR_W-1:0] : '0;
   assign if_pc_next = if_valid ? head[ADDR_W-1:0] + ADDR_W'(PC_STEP) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model, decode-side stream checker
// and a second instance with a wrapping reset PC.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic [15:0] if_pc_next;

   logic        w_req, w_gnt, w_rvalid, w_valid;
   logic [15:0] w_addr, w_rdata, w_instr, w_pc, w_pc_next;

   always #5 clk = ~clk;

   fetch_unit u_dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
      .if_pc(if_pc), .if_pc_next(if_pc_next)
   );

   fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
      .clk(clk), .rst(rst), .redirect(1'b0), .redirect_pc(16'h0000),
      .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .if_valid(w_valid), .if_ready(1'b1), .if_instr(w_instr),
      .if_pc(w_pc), .if_pc_next(w_pc_next)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory contents: a fixed scramble of the address.
   function automatic logic [15:0] memval(input logic [15:0] a);
      return 16'(a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Stimulus knobs written by the main sequence, read by the memory model.
   int          gnt_pct = 100, lat_min = 1, lat_max = 1;
   int          rand_redir = 0, redir_at = -1, rv_redir_idx = 0;
   logic [15:0] redir_tgt = 16'h0, rv_redir_tgt = 16'h0;

   // Memory model (owns imem_* inputs and redirect).
   logic [15:0] grant_log [$];
   logic        pending = 1'b0, rv_fired = 1'b0;
   int          cnt = 0, resp_idx = 0;
   logic [15:0] pend_addr = 16'h0;

   initial begin
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0;
      forever begin
         @(posedge clk); #1;
         if (!rst) begin
            imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0;
            pending = 0; resp_idx = 0; rv_fired = 0; grant_log.delete();
         end else begin
            if (pending) chk("single_outstanding", {31'd0, imem_req}, 32'd0);
            imem_rvalid = 0;
            redirect    = 0;
            if (pending) begin
               cnt--;
               if (cnt == 0) begin
                  imem_rvalid = 1;
                  imem_rdata  = memval(pend_addr);
                  pending     = 0;
                  resp_idx++;
               end
            end
            if (cyc == redir_at) begin
               redirect = 1; redirect_pc = redir_tgt;
            end
            if (imem_rvalid && resp_idx == rv_redir_idx) begin
               redirect = 1; redirect_pc = rv_redir_tgt; rv_fired = 1;
            end
            if (rand_redir != 0 && $urandom_range(0, 39) == 0) begin
               redirect = 1; redirect_pc = 16'($urandom) & 16'hFFFE;
            end
            imem_gnt = imem_req && !pending && ($urandom_range(1, 100) <= gnt_pct);
            if (imem_gnt) begin
               pending   = 1;
               cnt       = $urandom_range(lat_min, lat_max);
               pend_addr = imem_addr;
               grant_log.push_back(imem_addr);
            end
         end
      end
   end

   // Decode-side scoreboard: expected PCs pushed on reset/redirect, popped on accept.
   logic [15:0] exp_q [$];
   logic [15:0] top_pc = 16'h0, h_pc = 16'h0, h_instr = 16'h0, h_addr = 16'h0, e;
   logic        hold_p = 1'b0, reqh_p = 1'b0;
   int          acc_cnt = 0;

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         exp_q.delete(); top_pc = 16'h0000; hold_p = 0; reqh_p = 0;
      end else begin
         if (!if_valid) begin
            chk("idle_instr_pc", {if_instr, if_pc}, 32'd0);
            chk("idle_pc_next", {16'd0, if_pc_next}, 32'd0);
         end
         if (hold_p) begin
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_pc", {16'd0, if_pc}, {16'd0, h_pc});
            chk("hold_instr", {16'd0, if_instr}, {16'd0, h_instr});
         end
         if (reqh_p) begin
            chk("req_hold", {31'd0, imem_req}, 32'd1);
            chk("addr_hold", {16'd0, imem_addr}, {16'd0, h_addr});
         end
         if (if_valid && if_ready) begin
            while (exp_q.size() < 4) begin
               exp_q.push_back(top_pc);
               top_pc = top_pc + 16'd2;
            end
            e = exp_q.pop_front();
            chk("stream_pc", {16'd0, if_pc}, {16'd0, e});
            chk("stream_instr", {16'd0, if_instr}, {16'd0, memval(e)});
            chk("stream_pc_next", {16'd0, if_pc_next}, {16'd0, 16'(e + 16'd2)});
            acc_cnt++;
         end
         if (redirect) begin
            exp_q.delete(); top_pc = redirect_pc;
         end
         hold_p = if_valid && !if_ready && !redirect;
         h_pc = if_pc; h_instr = if_instr;
         reqh_p = imem_req && !imem_gnt && !redirect;
         h_addr = imem_addr;
      end
   end

   // Wrap instance: grant at once, respond one cycle later.
   logic [15:0] w_log [$];
   logic        w_pend = 1'b0, w_got = 1'b0;
   logic [15:0] w_paddr = 16'h0, w_first_pc = 16'h0, w_first_next = 16'h0;

   initial begin
      w_gnt = 0; w_rvalid = 0; w_rdata = 0;
      forever begin
         @(posedge clk); #1;
         if (!rst) begin
            w_gnt = 0; w_rvalid = 0; w_pend = 0; w_log.delete();
         end else begin
            w_rvalid = 0;
            if (w_pend) begin
               w_rvalid = 1; w_rdata = memval(w_paddr); w_pend = 0;
            end
            w_gnt = w_req && !w_pend;
            if (w_gnt) begin
               w_pend = 1; w_paddr = w_addr; w_log.push_back(w_addr);
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) w_got = 0;
      else if (w_valid && !w_got) begin
         w_got = 1; w_first_pc = w_pc; w_first_next = w_pc_next;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 0;
      #1;
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst_if_instr", {16'd0, if_instr}, 32'd0);
      chk("rst_if_pc", {16'd0, if_pc}, 32'd0);
      chk("rst_if_pc_next", {16'd0, if_pc_next}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", {16'd0, imem_addr}, 32'h0000);
   endtask

   int n0;

   initial begin
      if_ready = 1;

      // Straight-line fetch with immediate grant, one-cycle latency.
      do_reset();
      n0 = acc_cnt;
      repeat (12) @(negedge clk);
      chk("a_grant_count", {31'd0, grant_log.size() >= 3}, 32'd1);
      if (grant_log.size() >= 3) begin
         chk("a_addr0", {16'd0, grant_log[0]}, 32'h0000);
         chk("a_addr1", {16'd0, grant_log[1]}, 32'h0002);
         chk("a_addr2", {16'd0, grant_log[2]}, 32'h0004);
      end
      chk("a_delivered", {31'd0, (acc_cnt - n0) >= 3}, 32'd1);
      chk("wrap_grants", {31'd0, w_log.size() >= 2}, 32'd1);
      if (w_log.size() >= 2) begin
         chk("wrap_addr0", {16'd0, w_log[0]}, 32'hFFFE);
         chk("wrap_addr1", {16'd0, w_log[1]}, 32'h0000);
      end
      chk("wrap_got", {31'd0, w_got}, 32'd1);
      chk("wrap_first_pc", {16'd0, w_first_pc}, 32'hFFFE);
      chk("wrap_first_next", {16'd0, w_first_next}, 32'h0000);

      // Decode stalled: queue fills and requests stop.
      @(posedge clk); #1 if_ready = 0;
      do_reset();
      repeat (10) @(negedge clk);
      chk("b_req_off", {31'd0, imem_req}, 32'd0);
      chk("b_valid", {31'd0, if_valid}, 32'd1);
      chk("b_head_pc", {16'd0, if_pc}, 32'h0000);
      chk("b_grant_count", grant_log.size(), 32'd2);
      @(posedge clk); #1 if_ready = 1;
      for (int i = 0; i < 20 && grant_log.size() < 3; i++) @(negedge clk);
      chk("b_regrant", {31'd0, grant_log.size() >= 3}, 32'd1);
      if (grant_log.size() >= 3) chk("b_addr2", {16'd0, grant_log[2]}, 32'h0004);

      // Redirect in WAIT; stale response arrives three cycles later.
      lat_min = 4; lat_max = 4;
      do_reset();
      for (int i = 0; i < 20 && grant_log.size() < 1; i++) @(negedge clk);
      redir_tgt = 16'h0100;
      redir_at  = cyc + 1;
      n0 = acc_cnt;
      for (int i = 0; i < 40 && grant_log.size() < 2; i++) @(negedge clk);
      chk("c_regrant", {31'd0, grant_log.size() >= 2}, 32'd1);
      if (grant_log.size() >= 2) chk("c_addr", {16'd0, grant_log[1]}, 32'h0100);
      repeat (20) @(negedge clk);
      chk("c_delivered", {31'd0, acc_cnt > n0}, 32'd1);
      redir_at = -1;

      // Redirect coincident with rvalid in WAIT, one entry queued.
      lat_min = 1; lat_max = 1;
      @(posedge clk); #1 if_ready = 0;
      do_reset();
      rv_redir_tgt = 16'h0200;
      rv_redir_idx = 2;
      for (int i = 0; i < 30 && !rv_fired; i++) @(negedge clk);
      chk("d_fired", {31'd0, rv_fired}, 32'd1);
      chk("d_one_entry", {31'd0, if_valid}, 32'd1);
      @(negedge clk);
      chk("d_flushed", {31'd0, if_valid}, 32'd0);
      chk("d_req", {31'd0, imem_req}, 32'd1);
      chk("d_addr", {16'd0, imem_addr}, 32'h0200);
      rv_redir_idx = 0;
      @(posedge clk); #1 if_ready = 1;
      n0 = acc_cnt;
      for (int i = 0; i < 20 && grant_log.size() < 3; i++) @(negedge clk);
      chk("d_regrant", {31'd0, grant_log.size() >= 3}, 32'd1);
      if (grant_log.size() >= 3) chk("d_addr2", {16'd0, grant_log[2]}, 32'h0200);
      repeat (10) @(negedge clk);
      chk("d_delivered", {31'd0, acc_cnt > n0}, 32'd1);

      // Asynchronous reset in WAIT with an entry queued.
      lat_min = 3; lat_max = 3;
      @(posedge clk); #1 if_ready = 0;
      do_reset();
      for (int i = 0; i < 30 && grant_log.size() < 2; i++) @(negedge clk);
      chk("f_second_grant", {31'd0, grant_log.size() >= 2}, 32'd1);
      @(negedge clk);
      chk("f_valid_before", {31'd0, if_valid}, 32'd1);
      #2 rst = 0;
      #1;
      chk("f_valid_async", {31'd0, if_valid}, 32'd0);
      chk("f_req_async", {31'd0, imem_req}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      @(negedge clk);
      chk("f_req_after", {31'd0, imem_req}, 32'd1);
      chk("f_addr_after", {16'd0, imem_addr}, 32'h0000);
      chk("f_valid_after", {31'd0, if_valid}, 32'd0);

      // Randomised traffic: grants, latency, backpressure and redirects.
      gnt_pct = 60; lat_min = 1; lat_max = 4;
      @(posedge clk); #1 if_ready = 1;
      do_reset();
      rand_redir = 1;
      n0 = acc_cnt;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if_ready = ($urandom_range(0, 9) < 7);
      end
      rand_redir = 0;
      repeat (10) @(negedge clk);
      chk("rand_throughput", {31'd0, (acc_cnt - n0) > 100}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
